mm2s_stream: RTL and testbench

MM2S_STREAM -- requirements
Module: mm2s_stream

---
 rtl/mm2s_pkg.sv | 15 +
 rtl/stream_fifo2.sv | 53 +++++
 rtl/mm2s_stream.sv | 119 +++++++++++
 tb/tb_mm2s_stream.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm2s_pkg.sv
// Shared types for the result-matrix memory-to-stream reader.
// State encoding and skid buffer sizing live here.
package mm2s_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO between the memory read port and the stream output.
// Simultaneous push and pop is legal even when full.
module stream_fifo2
  import mm2s_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = count == CNT_W'(BUF_DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mm2s_stream.sv
// Streams an M1 x M3 result matrix from memory onto AXI-Stream.
// Reads are credit-limited so the 2-entry FIFO can never overflow.
module mm2s_stream
  import mm2s_pkg::*;
#(
  parameter int D_W          = 8,
  parameter int ADDR_W       = 12,
  parameter int MATRIXSIZE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] M1,
  input  logic [MATRIXSIZE_W-1:0] M3,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic signed [D_W-1:0]   rd_data,
  output logic signed [D_W-1:0]   m_axis_mm2s_tdata,
  output logic                    m_axis_mm2s_tvalid,
  input  logic                    m_axis_mm2s_tready,
  output logic                    m_axis_mm2s_tlast,
  output logic                    busy,
  output logic                    read_done
);

  localparam int TW = 2 * MATRIXSIZE_W;
  localparam int OW = CNT_W + 1;

  state_t           state;
  state_t           nxt;
  logic [TW-1:0]    total;
  logic [TW-1:0]    rd_idx;
  logic [TW-1:0]    beat_idx;
  logic             infl;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic [OW-1:0]    occ;
  logic             headroom;
  logic             last_rd;
  logic             done_evt;

  stream_fifo2 #(
    .W (D_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl),
    .pop   (pop),
    .din   (rd_data),
    .dout  (m_axis_mm2s_tdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign m_axis_mm2s_tvalid = !fifo_empty;
  assign m_axis_mm2s_tlast  = m_axis_mm2s_tvalid
                           && (beat_idx == total - 1'b1);
  assign pop     = m_axis_mm2s_tvalid && m_axis_mm2s_tready;
  assign rd_addr = rd_idx[ADDR_W-1:0];
  assign last_rd = rd_idx == total - 1'b1;

  // Occupancy after this edge's pop; a read issued now lands one edge later.
  assign occ = OW'(fifo_cnt) + OW'(infl) - OW'(pop);
  assign headroom = (!fifo_full || pop) && (occ < OW'(BUF_DEPTH));

  assign done_evt = ((state == STREAM) && (total == '0))
                 || ((state == DRAIN) && pop && m_axis_mm2s_tlast);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = STREAM;
      STREAM: begin
        if (total == '0)           nxt = DONE;
        else if (rd_en && last_rd) nxt = DRAIN;
      end
      DRAIN:   if (pop && m_axis_mm2s_tlast) nxt = DONE;
      DONE:    if (!start) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    busy  = state != IDLE;
    if ((state == STREAM) && (total != '0) && headroom)
      rd_en = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total     <= '0;
      rd_idx    <= '0;
      beat_idx  <= '0;
      infl      <= 1'b0;
      read_done <= 1'b0;
    end else begin
      infl      <= rd_en;
      read_done <= done_evt;
      if ((state == IDLE) && start) begin
        total    <= TW'(M1) * TW'(M3);
        rd_idx   <= '0;
        beat_idx <= '0;
      end else begin
        if (rd_en) rd_idx   <= rd_idx + 1'b1;
        if (pop)   beat_idx <= beat_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mm2s_stream.sv
// Scoreboard bench for mm2s_stream: directed transfers, monitor checks
// every beat, read address and read_done pulse against queued values.
module tb_mm2s_stream;

  localparam int D_W    = 8;
  localparam int ADDR_W = 12;
  localparam int MW     = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [MW-1:0]         M1;
  logic [MW-1:0]         M3;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic signed [D_W-1:0] rd_data;
  logic signed [D_W-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  busy;
  logic                  read_done;

  mm2s_stream #(
    .D_W          (D_W),
    .ADDR_W       (ADDR_W),
    .MATRIXSIZE_W (MW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .M1                 (M1),
    .M3                 (M3),
    .rd_en              (rd_en),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .m_axis_mm2s_tdata  (tdata),
    .m_axis_mm2s_tvalid (tvalid),
    .m_axis_mm2s_tready (tready),
    .m_axis_mm2s_tlast  (tlast),
    .busy               (busy),
    .read_done          (read_done)
  );

  always #5 clk = ~clk;

  logic signed [D_W-1:0] mem [0:255];

  always @(posedge clk)
    if (rd_en) rd_data <= mem[rd_addr[7:0]];

  typedef struct packed {
    logic signed [D_W-1:0] data;
    logic                  last;
  } beat_t;

  beat_t exp_q[$];

  int total_n   = 0;
  int bad_n     = 0;
  int done_cnt  = 0;
  int rd_cnt    = 0;
  int beats     = 0;
  int exp_addr  = 0;
  int cyc       = 0;
  int first_cyc = -1;
  int last_cyc  = -1;
  bit zero_ok   = 1'b0;

  task automatic chk(string name, logic signed [63:0] act,
                     logic signed [63:0] req);
    total_n++;
    if (act !== req) begin
      bad_n++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a handshake seen here completes on the next rising edge.
  initial begin : mon
    bit                    prev_stall;
    bit                    last_hs;
    logic signed [D_W-1:0] prev_data;
    beat_t                 b;
    prev_stall = 1'b0;
    last_hs    = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
        last_hs    = 1'b0;
      end else begin
        if (last_hs)
          chk("read_done_after_tlast", read_done, 1);
        else if (read_done && !zero_ok)
          chk("read_done_spurious", read_done, 0);
        if (read_done) done_cnt++;
        if (prev_stall) begin
          chk("tvalid_held", tvalid, 1);
          chk("tdata_held", tdata, prev_data);
        end
        if (rd_en) begin
          chk("rd_addr", rd_addr, exp_addr);
          exp_addr++;
          rd_cnt++;
        end
        last_hs = 1'b0;
        if (tvalid && tready) begin
          beats++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            b = exp_q.pop_front();
            chk("tdata", tdata, b.data);
            chk("tlast", tlast, b.last);
          end
          last_hs = tlast;
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
      end
    end
  end

  task automatic load(int m1, int m3, int mul, int off);
    logic signed [D_W-1:0] v;
    beat_t                 e;
    int                    n;
    n = m1 * m3;
    M1 = MW'(m1);
    M3 = MW'(m3);
    for (int i = 0; i < n; i++) begin
      v      = D_W'(i * mul + off);
      mem[i] = v;
      e.data = v;
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
    exp_addr  = 0;
    rd_cnt    = 0;
    beats     = 0;
    first_cyc = -1;
    last_cyc  = -1;
  endtask

  task automatic wait_done(int target, int bound, bit toggle);
    for (int k = 0; k < bound; k++) begin
      @(posedge clk); #1;
      if (toggle) tready = ~tready;
      if (done_cnt >= target) break;
    end
    chk("done_reached", done_cnt >= target, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic finish_xfer();
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("busy_idle", busy, 0);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_tlast"}, tlast, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_read_done"}, read_done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst    = 1'b1;
    start  = 1'b0;
    tready = 1'b0;
    M1     = '0;
    M3     = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 2x3 back-to-back
    load(2, 3, 1, 1);
    tready = 1'b1;
    start  = 1'b1;
    lat    = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!tvalid && lat < 20);
    chk("first_tvalid_latency", lat, 4);
    wait_done(1, 40, 1'b0);
    chk("t1_burst_span", last_cyc - first_cyc, 5);
    chk("t1_reads", rd_cnt, 6);
    chk("t1_beats", beats, 6);
    finish_xfer();

    // 2x3 with tready toggling
    load(2, 3, 1, 1);
    tready = 1'b1;
    start  = 1'b1;
    wait_done(2, 60, 1'b1);
    chk("t2_reads", rd_cnt, 6);
    chk("t2_beats", beats, 6);
    finish_xfer();

    // sink stalled for 10 cycles
    load(2, 3, -2, 100);
    tready = 1'b0;
    start  = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("t3_stalled_reads", rd_cnt, 2);
    chk("t3_stalled_beats", beats, 0);
    chk("t3_stalled_tvalid", tvalid, 1);
    tready = 1'b1;
    wait_done(3, 40, 1'b0);
    chk("t3_reads", rd_cnt, 6);
    chk("t3_beats", beats, 6);
    finish_xfer();

    // empty matrix
    load(0, 5, 1, 1);
    zero_ok = 1'b1;
    tready  = 1'b1;
    start   = 1'b1;
    wait_done(4, 20, 1'b0);
    chk("t4_reads", rd_cnt, 0);
    chk("t4_beats", beats, 0);
    finish_xfer();
    zero_ok = 1'b0;

    // reset after beat 3 of 4x4, then a fresh 4x4
    load(4, 4, 7, -40);
    tready = 1'b1;
    start  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (beats >= 3) break;
    end
    chk("t5_beats_before_rst", beats, 3);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    load(4, 4, 5, -30);
    start = 1'b1;
    wait_done(5, 60, 1'b0);
    chk("t5_reads", rd_cnt, 16);
    chk("t5_beats", beats, 16);
    finish_xfer();

    // start held through completion
    load(2, 3, 2, 9);
    tready = 1'b1;
    start  = 1'b1;
    wait_done(6, 40, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("t6_done_once", done_cnt, 6);
    chk("t6_reads_once", rd_cnt, 6);
    chk("t6_busy_held", busy, 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("t6_busy_released", busy, 0);
    load(2, 3, -1, 50);
    start = 1'b1;
    wait_done(7, 40, 1'b0);
    chk("t6_second_reads", rd_cnt, 6);
    chk("t6_second_beats", beats, 6);
    finish_xfer();

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
